// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/execute requesters, the arbiter and the memory port.
// Signal suffixes are from the arbiter's point of view.
interface mem_arbiter_if;
    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_resp_valid_o;
    logic [31:0] ifu_rdata_o;
    logic        ifu_err_o;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic [31:0] lsu_addr_i;
    logic        lsu_we_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_wmask_i;
    logic        lsu_resp_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_resp_err_i;

    // Arbiter side.
    modport slave (
        input  ifu_req_valid_i, ifu_addr_i,
        output ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o, ifu_err_o,
        input  lsu_req_valid_i, lsu_addr_i, lsu_we_i, lsu_wdata_i, lsu_wmask_i,
        output lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o, lsu_err_o,
        output mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wmask_o,
        input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
    );

    // Requester/memory-model side.
    modport master (
        output ifu_req_valid_i, ifu_addr_i,
        input  ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o, ifu_err_o,
        output lsu_req_valid_i, lsu_addr_i, lsu_we_i, lsu_wdata_i, lsu_wmask_i,
        input  lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o, lsu_err_o,
        input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wmask_o,
        output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU reads and LSU
// loads/stores. Sequence: accept -> downstream request -> response -> one-cycle
// registered reply to the owner. A timeout converts a hung bus into an error reply.
module mem_arbiter #(
    parameter bit          LSU_PRIORITY   = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IFU_REQ  = 3'd1,
        ST_IFU_RESP = 3'd2,
        ST_LSU_REQ  = 3'd3,
        ST_LSU_RESP = 3'd4
    } state_e;

    localparam bit             TO_EN       = (TIMEOUT_CYCLES != 0);
    localparam int unsigned    TO_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_INT);

    state_e           state_q, state_d;
    logic             last_lsu_q;      // 1: last grant went to the LSU
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic             ifu_vld_q, lsu_vld_q;
    logic [31:0]      ifu_rdata_q, lsu_rdata_q;
    logic             ifu_err_q, lsu_err_q;

    logic ifu_ready_s, lsu_ready_s, grant_lsu_s;
    logic busy_s, owner_lsu_s, done_s, tmo_s, tmo_hit_s;

    // Next-state, grant and completion/timeout decode.
    always_comb begin
        state_d     = state_q;
        ifu_ready_s = 1'b0;
        lsu_ready_s = 1'b0;
        grant_lsu_s = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        busy_s      = (state_q != ST_IDLE);
        owner_lsu_s = (state_q == ST_LSU_REQ) || (state_q == ST_LSU_RESP);
        tmo_hit_s   = TO_EN && busy_s && (cnt_q == TO_LAST);
        case (state_q)
            ST_IDLE: begin
                if (bus.ifu_req_valid_i && bus.lsu_req_valid_i) begin
                    grant_lsu_s = LSU_PRIORITY ? 1'b1 : !last_lsu_q;
                end else begin
                    grant_lsu_s = bus.lsu_req_valid_i;
                end
                lsu_ready_s = bus.lsu_req_valid_i && grant_lsu_s;
                ifu_ready_s = bus.ifu_req_valid_i && !grant_lsu_s;
                if (lsu_ready_s) begin
                    state_d = ST_LSU_REQ;
                end else if (ifu_ready_s) begin
                    state_d = ST_IFU_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IFU_REQ, ST_LSU_REQ: begin
                if (tmo_hit_s) begin
                    tmo_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.mem_req_ready_i) begin
                    state_d = (state_q == ST_LSU_REQ) ? ST_LSU_RESP : ST_IFU_RESP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_IFU_RESP, ST_LSU_RESP: begin
                // A response in the timeout cycle still completes normally.
                if (bus.mem_resp_valid_i) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit_s) begin
                    tmo_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and last-grant tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_lsu_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (lsu_ready_s) begin
                last_lsu_q <= 1'b1;
            end else if (ifu_ready_s) begin
                last_lsu_q <= 1'b0;
            end
        end
    end

    // Capture the accepted request; loads and fetches always carry an empty mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= 32'h0000_0000;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            wmask_q <= 4'b0000;
        end else if (lsu_ready_s) begin
            addr_q  <= bus.lsu_addr_i;
            we_q    <= bus.lsu_we_i;
            wdata_q <= bus.lsu_wdata_i;
            wmask_q <= bus.lsu_we_i ? bus.lsu_wmask_i : 4'b0000;
        end else if (ifu_ready_s) begin
            addr_q  <= bus.ifu_addr_i;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            wmask_q <= 4'b0000;
        end
    end

    // Timeout counter: cleared on accept, counts every busy cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (ifu_ready_s || lsu_ready_s) begin
            cnt_q <= '0;
        end else if (busy_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered one-cycle reply to the owner; data/err hold between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifu_vld_q   <= 1'b0;
            lsu_vld_q   <= 1'b0;
            ifu_rdata_q <= 32'h0000_0000;
            lsu_rdata_q <= 32'h0000_0000;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
        end else begin
            ifu_vld_q <= 1'b0;
            lsu_vld_q <= 1'b0;
            if (done_s || tmo_s) begin
                if (owner_lsu_s) begin
                    lsu_vld_q   <= 1'b1;
                    lsu_rdata_q <= done_s ? bus.mem_rdata_i : 32'h0000_0000;
                    lsu_err_q   <= done_s ? bus.mem_resp_err_i : 1'b1;
                end else begin
                    ifu_vld_q   <= 1'b1;
                    ifu_rdata_q <= done_s ? bus.mem_rdata_i : 32'h0000_0000;
                    ifu_err_q   <= done_s ? bus.mem_resp_err_i : 1'b1;
                end
            end
        end
    end

    assign bus.ifu_req_ready_o  = ifu_ready_s;
    assign bus.lsu_req_ready_o  = lsu_ready_s;
    assign bus.ifu_resp_valid_o = ifu_vld_q;
    assign bus.ifu_rdata_o      = ifu_rdata_q;
    assign bus.ifu_err_o        = ifu_err_q;
    assign bus.lsu_resp_valid_o = lsu_vld_q;
    assign bus.lsu_rdata_o      = lsu_rdata_q;
    assign bus.lsu_err_o        = lsu_err_q;
    assign bus.mem_req_valid_o  = (state_q == ST_IFU_REQ) || (state_q == ST_LSU_REQ);
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_we_o         = we_q;
    assign bus.mem_wdata_o      = wdata_q;
    assign bus.mem_wmask_o      = wmask_q;

endmodule
